// File: rtl/multi_domain_rtc.sv
// multi_domain_rtc: hardware real-time clock for the TSN timestamp path.
//
// Keeps a free-running sec / ns / fraction time base. The 40-bit period (39:32 ns, 31:0
// fraction) is split into the part kept in the accumulator (ns + FRAC_W fraction bits) and a
// delta-sigma residue that carries into the next tick, so long-term rate is exact. A slewed
// phase adjustment adds adj_period to every tick for adj_len cycles after an adj_delay wait.
// NUM_DOM derived time domains apply per-domain signed sec/ns offsets, registered one cycle
// after the local time.
//
// Optional feature: define RTC_FLAT_NS_EN to produce dom_ns_flat = sec[31:0]*1e9 + ns (3-stage
// pipeline behind dom_*). Without it dom_ns_flat is tied to 0.
//
// Ports
//   clk, rst                   clock, synchronous active-low reset
//   time_ld/time_ns_in/_sec_in load time base (clears residue, aborts adjustment)
//   period_ld/period_in        load nominal period
//   adj_ld/adj_delay/adj_len/adj_period, adj_busy/adj_done   slewed adjustment
//   off_ld/off_sel/off_ns_in/off_sec_in                       per-domain offset load
//   time_ns/time_sec/one_pps   local time and seconds-rollover pulse
//   dom_ns/dom_sec/dom_ns_flat domain times
module multi_domain_rtc #(
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned SEC_W       = 48,
  parameter int unsigned NUM_DOM     = 2,
  parameter logic [39:0] INIT_PERIOD = 40'h8_0000_0000,
  localparam int unsigned IDX_W      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1,
  localparam int unsigned NS_W       = 30 + FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     time_ld,
  input  logic [NS_W-1:0]          time_ns_in,
  input  logic [SEC_W-1:0]         time_sec_in,
  input  logic                     period_ld,
  input  logic [39:0]              period_in,
  input  logic                     adj_ld,
  input  logic [31:0]              adj_delay,
  input  logic [15:0]              adj_len,
  input  logic [39:0]              adj_period,
  output logic                     adj_busy,
  output logic                     adj_done,
  input  logic                     off_ld,
  input  logic [IDX_W-1:0]         off_sel,
  input  logic [31:0]              off_ns_in,
  input  logic [47:0]              off_sec_in,
  output logic [NS_W-1:0]          time_ns,
  output logic [SEC_W-1:0]         time_sec,
  output logic                     one_pps,
  output logic [NUM_DOM*32-1:0]    dom_ns,
  output logic [NUM_DOM*SEC_W-1:0] dom_sec,
  output logic [NUM_DOM*64-1:0]    dom_ns_flat
);

  localparam int unsigned RES_W  = 32 - FRAC_W;
  localparam int unsigned STEP_W = 8 + FRAC_W;
  localparam int unsigned ACC_W  = NS_W + 2;
  localparam logic [ACC_W-1:0] MOD = ACC_W'(64'd1_000_000_000 << FRAC_W);
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StSlew = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Time base state
  logic [39:0]      period_q, period_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [NS_W-1:0]  acc_q, acc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             pps_q, pps_d;

  // Adjustment state
  logic [1:0]  st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [39:0] aper_q, aper_d;
  logic        adj_accept;

  // Offsets and domains
  logic [NUM_DOM-1:0][31:0]      off_ns_q;
  logic [NUM_DOM-1:0]            off_neg_q;
  logic [NUM_DOM-1:0][46:0]      off_sec_q;
  logic [NUM_DOM-1:0][31:0]      dom_ns_q, dom_ns_d;
  logic [NUM_DOM-1:0][SEC_W-1:0] dom_sec_q, dom_sec_d;

  // Tick datapath: sum, sum-minus-modulo and sum-plus-modulo are formed in parallel and the
  // sign bits pick the result. The plus-modulo path only matters for a negative effective
  // period, which can happen while slewing with a large negative delta.
  logic [39:0]      eff;
  logic [RES_W:0]   res_sum;
  logic [STEP_W-1:0] step;
  logic [ACC_W-1:0] sum, sum_dn, sum_up;
  logic             unused_bits;

  assign eff     = period_q + ((st_q == StSlew) ? aper_q : 40'd0);
  assign res_sum = {1'b0, res_q} + {1'b0, eff[RES_W-1:0]};
  assign step    = eff[39:RES_W];
  assign sum     = {2'b00, acc_q} + {{(ACC_W-STEP_W){step[STEP_W-1]}}, step}
                   + ACC_W'(res_sum[RES_W]);
  assign sum_dn  = sum - MOD;
  assign sum_up  = sum + MOD;
  assign unused_bits = ^{sum[ACC_W-2:NS_W], sum_dn[ACC_W-2:NS_W], sum_up[ACC_W-1:NS_W]};

  always_comb begin
    acc_d    = acc_q;
    sec_d    = sec_q;
    res_d    = res_q;
    pps_d    = 1'b0;
    period_d = period_ld ? period_in : period_q;
    if (time_ld) begin
      acc_d = time_ns_in;
      sec_d = time_sec_in;
      res_d = '0;
    end else begin
      res_d = res_sum[RES_W-1:0];
      if (sum[ACC_W-1]) begin
        acc_d = sum_up[NS_W-1:0];
        sec_d = sec_q - SEC_W'(1);
      end else if (!sum_dn[ACC_W-1]) begin
        acc_d = sum_dn[NS_W-1:0];
        sec_d = sec_q + SEC_W'(1);
        pps_d = 1'b1;
      end else begin
        acc_d = sum[NS_W-1:0];
      end
    end
  end

  // Accepted from IDLE or DONE (both non-busy); time_ld takes priority and aborts.
  assign adj_accept = adj_ld && !time_ld && ((st_q == StIdle) || (st_q == StDone));

  // cnt holds the remaining cycles of the current phase, so WAIT lasts adj_delay cycles and
  // SLEW lasts adj_len cycles.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    aper_d = aper_q;
    if (time_ld) begin
      st_d  = StIdle;
      cnt_d = '0;
    end else if (adj_accept) begin
      len_d  = adj_len;
      aper_d = adj_period;
      if (adj_delay != 32'd0) begin
        st_d  = StWait;
        cnt_d = adj_delay;
      end else if (adj_len != 16'd0) begin
        st_d  = StSlew;
        cnt_d = 32'(adj_len);
      end else begin
        st_d = StDone;
      end
    end else begin
      case (st_q)
        StWait: begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            if (len_q != 16'd0) begin
              st_d  = StSlew;
              cnt_d = 32'(len_q);
            end else begin
              st_d = StDone;
            end
          end
        end
        StSlew: begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) st_d = StDone;
        end
        StDone:  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end
  end

  // Domain d is computed from the registered local time and offset.
  logic [31:0] t_ns;
  assign t_ns = {2'b00, acc_q[NS_W-1:FRAC_W]};

  always_comb begin
    dom_ns_d  = '0;
    dom_sec_d = '0;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (!off_neg_q[d]) begin
        if (t_ns + off_ns_q[d] >= NS_PER_SEC) begin
          dom_ns_d[d]  = t_ns + off_ns_q[d] - NS_PER_SEC;
          dom_sec_d[d] = sec_q + SEC_W'(off_sec_q[d]) + SEC_W'(1);
        end else begin
          dom_ns_d[d]  = t_ns + off_ns_q[d];
          dom_sec_d[d] = sec_q + SEC_W'(off_sec_q[d]);
        end
      end else begin
        if (t_ns < off_ns_q[d]) begin
          dom_ns_d[d]  = t_ns + NS_PER_SEC - off_ns_q[d];
          dom_sec_d[d] = sec_q - SEC_W'(off_sec_q[d]) - SEC_W'(1);
        end else begin
          dom_ns_d[d]  = t_ns - off_ns_q[d];
          dom_sec_d[d] = sec_q - SEC_W'(off_sec_q[d]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_q  <= INIT_PERIOD;
      res_q     <= '0;
      acc_q     <= '0;
      sec_q     <= '0;
      pps_q     <= 1'b0;
      st_q      <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      aper_q    <= '0;
      off_ns_q  <= '0;
      off_neg_q <= '0;
      off_sec_q <= '0;
      dom_ns_q  <= '0;
      dom_sec_q <= '0;
    end else begin
      period_q  <= period_d;
      res_q     <= res_d;
      acc_q     <= acc_d;
      sec_q     <= sec_d;
      pps_q     <= pps_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      aper_q    <= aper_d;
      dom_ns_q  <= dom_ns_d;
      dom_sec_q <= dom_sec_d;
      // Out-of-range ns offsets are dropped so domain ns stays below 1e9.
      for (int d = 0; d < NUM_DOM; d++) begin
        if (off_ld && (off_ns_in < NS_PER_SEC) && (off_sel == IDX_W'(d))) begin
          off_ns_q[d]  <= off_ns_in;
          off_neg_q[d] <= off_sec_in[47];
          off_sec_q[d] <= off_sec_in[46:0];
        end
      end
    end
  end

  assign time_ns  = acc_q;
  assign time_sec = sec_q;
  assign one_pps  = pps_q;
  assign adj_busy = (st_q == StWait) || (st_q == StSlew);
  assign adj_done = (st_q == StDone);
  assign dom_ns   = dom_ns_q;
  assign dom_sec  = dom_sec_q;

`ifdef RTC_FLAT_NS_EN
  // register -> multiply -> add; output lags dom_* by three cycles.
  logic [NUM_DOM-1:0][31:0] fl_sec_q, fl_ns_q, fl_ns2_q;
  logic [NUM_DOM-1:0][63:0] fl_prod_q, fl_out_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fl_sec_q  <= '0;
      fl_ns_q   <= '0;
      fl_ns2_q  <= '0;
      fl_prod_q <= '0;
      fl_out_q  <= '0;
    end else begin
      for (int d = 0; d < NUM_DOM; d++) begin
        fl_sec_q[d]  <= 32'(dom_sec_q[d]);
        fl_ns_q[d]   <= dom_ns_q[d];
        fl_prod_q[d] <= 64'(fl_sec_q[d]) * 64'd1_000_000_000;
        fl_ns2_q[d]  <= fl_ns_q[d];
        fl_out_q[d]  <= fl_prod_q[d] + 64'(fl_ns2_q[d]);
      end
    end
  end

  assign dom_ns_flat = fl_out_q;
`else
  assign dom_ns_flat = '0;
`endif

endmodule
